// File: rtl/mem_pkg.sv
// Shared types and constants for the memory access controller: FSM states,
// byte-lane selection and the PREP address perturbation mask.
package mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PREP  = 3'd1,
    ST_RD    = 3'd2,
    ST_MERGE = 3'd3,
    ST_WR    = 3'd4,
    ST_REL   = 3'd5,
    ST_RESP  = 3'd6
  } state_e;

  localparam int unsigned MEM_BYTES_DEF = 64;

  // Big-endian word: the high lane [15:8] is the byte at the word address.
  typedef enum logic {
    LANE_HI = 1'b0,
    LANE_LO = 1'b1
  } lane_e;

  localparam logic [15:0] PREP_MASK = 16'h0002;

endpackage

// File: rtl/mem_lane_merge.sv
// Byte-lane handling on a 16-bit memory word: extracts the selected byte for
// loads and splices a new byte into the selected lane for byte stores.
module mem_lane_merge
  import mem_pkg::*;
(
  input  logic [15:0] word_i,
  input  lane_e       lane_i,
  input  logic [7:0]  byte_i,
  output logic [15:0] load_o,
  output logic [15:0] merged_o
);

  // Lane select and lane merge
  always_comb begin
    load_o   = 16'h0000;
    merged_o = word_i;
    case (lane_i)
      LANE_LO: begin
        load_o   = {8'h00, word_i[7:0]};
        merged_o = {word_i[15:8], byte_i};
      end
      default: begin
        load_o   = {8'h00, word_i[15:8]};
        merged_o = {byte_i, word_i[7:0]};
      end
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store controller for a memory that only reacts to Addr/DataIn changes:
// every access starts with a perturbed-address PREP cycle before the real one.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEF,
  parameter int unsigned SETTLE    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic        req_byte,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        mem_rw,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);

  localparam logic [16:0] SIZE_W    = 17'(MEM_BYTES);
  localparam logic [15:0] LAST_ADDR = 16'(MEM_BYTES - 1);
  localparam logic [3:0]  SETTLE_M1 = 4'(SETTLE - 1);

  state_e      state_q;
  logic        we_q, byte_q, pend_q;
  lane_e       lane_q;
  logic [15:0] eff_q, word_q;
  logic [7:0]  bdata_q;
  logic [3:0]  cnt_q;
  logic        mem_rw_q, rsp_valid_q, rsp_err_q;
  logic [15:0] mem_addr_q, mem_wdata_q, rsp_rdata_q;

  logic [15:0] eff_d;
  lane_e       lane_d;
  logic        err_d;
  logic [15:0] load_s, merged_s;

  // Request decode: effective word address, byte lane and range error
  always_comb begin
    eff_d  = req_addr;
    lane_d = LANE_HI;
    err_d  = 1'b0;
    if (req_byte) begin
      err_d = ({1'b0, req_addr} >= SIZE_W);
      if (req_addr == LAST_ADDR) begin
        eff_d  = req_addr - 16'd1;
        lane_d = LANE_LO;
      end else begin
        eff_d  = req_addr;
        lane_d = LANE_HI;
      end
    end else begin
      err_d = ({1'b0, req_addr} >= (SIZE_W - 17'd1));
    end
  end

  mem_lane_merge u_lane (
    .word_i   (mem_rdata),
    .lane_i   (lane_q),
    .byte_i   (bdata_q),
    .load_o   (load_s),
    .merged_o (merged_s)
  );

  // Access sequencer with registered memory and response outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      byte_q      <= 1'b0;
      pend_q      <= 1'b0;
      lane_q      <= LANE_HI;
      eff_q       <= 16'h0000;
      word_q      <= 16'h0000;
      bdata_q     <= 8'h00;
      cnt_q       <= 4'd0;
      mem_rw_q    <= 1'b0;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 16'h0000;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 16'h0000;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            byte_q  <= req_byte;
            lane_q  <= lane_d;
            eff_q   <= eff_d;
            word_q  <= req_wdata;
            bdata_q <= req_wdata[7:0];
            if (err_d) begin
              pend_q  <= 1'b1;
              state_q <= ST_RESP;
            end else begin
              mem_rw_q   <= 1'b0;
              mem_addr_q <= eff_d ^ PREP_MASK;
              state_q    <= ST_PREP;
            end
          end
        end
        ST_PREP: begin
          cnt_q      <= SETTLE_M1;
          mem_addr_q <= eff_q;
          if (we_q && !byte_q) begin
            mem_rw_q    <= 1'b1;
            mem_wdata_q <= word_q;
            state_q     <= ST_WR;
          end else begin
            mem_rw_q <= 1'b0;
            state_q  <= ST_RD;
          end
        end
        ST_RD: begin
          if (cnt_q == 4'd0) begin
            if (we_q) begin
              word_q     <= merged_s;
              mem_addr_q <= eff_q ^ PREP_MASK;
              state_q    <= ST_MERGE;
            end else begin
              rsp_rdata_q <= byte_q ? load_s : mem_rdata;
              rsp_err_q   <= 1'b0;
              rsp_valid_q <= 1'b1;
              pend_q      <= 1'b0;
              state_q     <= ST_RESP;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_MERGE: begin
          mem_rw_q    <= 1'b1;
          mem_addr_q  <= eff_q;
          mem_wdata_q <= word_q;
          state_q     <= ST_WR;
        end
        ST_WR: begin
          mem_rw_q <= 1'b0;
          state_q  <= ST_REL;
        end
        ST_REL: begin
          rsp_rdata_q <= 16'h0000;
          rsp_err_q   <= 1'b0;
          rsp_valid_q <= 1'b1;
          pend_q      <= 1'b0;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          // An error enters RESP straight from IDLE and emits its pulse one edge later.
          if (pend_q) begin
            pend_q      <= 1'b0;
            rsp_rdata_q <= 16'h0000;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          mem_rw_q <= 1'b0;
          pend_q   <= 1'b0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready = (state_q == ST_IDLE) && rst_n;
  assign busy      = (state_q != ST_IDLE);
  assign mem_rw    = mem_rw_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a 64-byte big-endian byte-array
// memory; checks latency, data, range errors and reset during a write.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, req_byte = 1'b0;
  logic [15:0] req_addr = 16'h0000, req_wdata = 16'h0000;
  logic        req_ready, rsp_valid, rsp_err, busy, mem_rw;
  logic [15:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;

  logic [7:0]  mem [0:63];
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.MEM_BYTES(64), .SETTLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory read port: big-endian, out-of-range bytes read as zero
  always_comb begin
    int a;
    a = int'(mem_addr);
    mem_rdata = 16'h0000;
    if (a < 64) mem_rdata[15:8] = mem[a];
    if (a + 1 < 64) mem_rdata[7:0] = mem[a + 1];
  end

  // Memory write port
  always @(posedge clk) begin
    if (mem_rw) begin
      if (int'(mem_addr) < 64) mem[int'(mem_addr)] <= mem_wdata[15:8];
      if (int'(mem_addr) + 1 < 64) mem[int'(mem_addr) + 1] <= mem_wdata[7:0];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 10; i++) begin
      if (req_ready) break;
      @(posedge clk); #1;
    end
    check("ready_before_req", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic run(input string tag, input logic we, input logic byt,
                     input logic [15:0] addr, input logic [15:0] wdata,
                     input logic [15:0] eff, input logic err_exp, input int lat_exp,
                     input logic chk_data, input logic [15:0] rdata_exp);
    logic [15:0] addr_before;
    int lat;
    int viol;
    int moved;
    logic [15:0] rd;
    logic er;
    lat = 0; viol = 0; moved = 0; rd = 16'hxxxx; er = 1'bx;
    wait_ready();
    addr_before = mem_addr;
    req_valid = 1'b1; req_we = we; req_byte = byt; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = ~we; req_byte = ~byt; req_addr = 16'hFFFF; req_wdata = 16'hDEAD;
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    check({tag, "_prep_addr"}, {16'd0, mem_addr}, {16'd0, err_exp ? addr_before : (eff ^ 16'h0002)});
    for (int n = 1; n <= 40; n++) begin
      if (mem_rw && mem_addr !== eff) viol++;
      if (mem_addr !== addr_before) moved++;
      if (rsp_valid) begin
        lat = n - 1; rd = rsp_rdata; er = rsp_err;
        break;
      end
      @(posedge clk); #1;
    end
    check({tag, "_latency"}, lat, lat_exp);
    check({tag, "_err"}, {31'd0, er}, {31'd0, err_exp});
    check({tag, "_rw_addr"}, viol, 0);
    if (err_exp) begin
      check({tag, "_rdata"}, {16'd0, rd}, 32'd0);
      check({tag, "_addr_moved"}, moved, 0);
    end else if (chk_data) begin
      check({tag, "_rdata"}, {16'd0, rd}, {16'd0, rdata_exp});
    end
  endtask

  initial begin
    int seen;
    for (int i = 0; i < 64; i++) mem[i] = 8'(i);
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, req_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_mem", {15'd0, mem_rw, mem_addr}, 32'd0);
    check("rst_rsp", {15'd0, rsp_valid, rsp_rdata}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    run("wst_1234", 1'b1, 1'b0, 16'h0010, 16'h1234, 16'h0010, 1'b0, 3, 1'b0, 16'h0000);
    run("wld_1234", 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0010, 1'b0, 2, 1'b1, 16'h1234);
    run("bst_ab",   1'b1, 1'b1, 16'h0011, 16'h77AB, 16'h0011, 1'b0, 5, 1'b0, 16'h0000);
    run("wld_12ab", 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0010, 1'b0, 2, 1'b1, 16'h12AB);
    run("bld_12",   1'b0, 1'b1, 16'h0012, 16'h0000, 16'h0012, 1'b0, 2, 1'b1, 16'h0012);
    run("bst_63",   1'b1, 1'b1, 16'h003F, 16'h995A, 16'h003E, 1'b0, 5, 1'b0, 16'h0000);
    run("bld_63",   1'b0, 1'b1, 16'h003F, 16'h0000, 16'h003E, 1'b0, 2, 1'b1, 16'h005A);
    run("bld_62",   1'b0, 1'b1, 16'h003E, 16'h0000, 16'h003E, 1'b0, 2, 1'b1, 16'h003E);
    run("wld_63",   1'b0, 1'b0, 16'h003F, 16'h0000, 16'h0000, 1'b1, 1, 1'b0, 16'h0000);
    run("bld_64",   1'b0, 1'b1, 16'h0040, 16'h0000, 16'h0000, 1'b1, 1, 1'b0, 16'h0000);
    run("wst_beef", 1'b1, 1'b0, 16'h0020, 16'hBEEF, 16'h0020, 1'b0, 3, 1'b0, 16'h0000);
    run("wld_beef1", 1'b0, 1'b0, 16'h0020, 16'h0000, 16'h0020, 1'b0, 2, 1'b1, 16'hBEEF);
    run("wld_beef2", 1'b0, 1'b0, 16'h0020, 16'h0000, 16'h0020, 1'b0, 2, 1'b1, 16'hBEEF);
    check("mem_byte_12", {24'd0, mem[18]}, 32'h12);

    // Reset asserted while the controller is in WR
    wait_ready();
    req_valid = 1'b1; req_we = 1'b1; req_byte = 1'b0; req_addr = 16'h0030; req_wdata = 16'h7777;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("wr_rw_high", {31'd0, mem_rw}, 32'd1);
    check("wr_addr", {16'd0, mem_addr}, 32'h0030);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_rw", {31'd0, mem_rw}, 32'd0);
    check("rst_async_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int n = 0; n < 6; n++) begin
      @(posedge clk); #1;
      if (rsp_valid) seen++;
    end
    check("rst_no_rsp", seen, 0);
    check("rst_byte_2f", {24'd0, mem[47]}, 32'h2F);
    check("rst_byte_32", {24'd0, mem[50]}, 32'h32);
    run("wld_after_rst", 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0010, 1'b0, 2, 1'b1, 16'h12AB);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter MEM_BYTES, default 64: byte capacity of the attached memory; legal byte addresses are 0..MEM_BYTES-1.
REQ-002 Parameter SETTLE, default 1: cycles mem_addr is held in the read state before mem_rdata is sampled; legal range 1..15.
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 req_valid  in  1  request present.
REQ-006 req_ready  out  1  controller idle; a request is accepted on any rising edge where req_valid && req_ready.
REQ-007 req_we  in  1  1 = store, 0 = load.
REQ-008 req_byte  in  1  1 = byte access, 0 = 16-bit word access.
REQ-009 req_addr  in  16  byte address.
REQ-010 req_wdata  in  16  store data; a byte store uses [7:0].
REQ-011 rsp_valid  out  1  one-cycle completion pulse; it has no backpressure.
REQ-012 rsp_rdata  out  16  load data, valid with rsp_valid; a byte load returns {8'h00, byte}.
REQ-013 rsp_err  out  1  address error, valid with rsp_valid.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 mem_rw  out  1  drives the memory MemRW: 1 = write.
REQ-016 mem_addr  out  16  drives the memory Addr.
REQ-017 mem_wdata  out  16  drives the memory DataIn; big-endian, [15:8] goes to byte Addr.
REQ-018 mem_rdata  in  16  from the memory DataOut.

Function
REQ-019 The memory updates only when mem_addr or mem_wdata changes, so every access shall begin with a PREP cycle: mem_rw=0, mem_addr = eff_addr ^ 16'h0002.
REQ-020 eff_addr rule:
- word access: eff_addr = req_addr;
- byte access at MEM_BYTES-1: eff_addr = req_addr-1, low lane;
- any other byte access: eff_addr = req_addr, high lane.
REQ-021 Range errors:
- a word access with req_addr >= MEM_BYTES-1 is an error;
- a byte access with req_addr >= MEM_BYTES is an error.
REQ-022 On an error the controller goes IDLE->RESP with rsp_err=1 and rsp_rdata=0, and leaves mem_* unchanged.
REQ-023 FSM states: IDLE, PREP, RD, MERGE, WR, REL, RESP.
REQ-024 Load path: IDLE->PREP->RD; RD holds mem_addr=eff_addr with mem_rw=0 for SETTLE cycles, samples mem_rdata, then goes to RESP.
REQ-025 Word store path: IDLE->PREP->WR->REL->RESP.
REQ-026 Byte store path: IDLE->PREP->RD->MERGE->WR->REL->RESP. MERGE replaces the selected lane of the sampled word with req_wdata[7:0] and drives mem_rw=0, mem_addr=eff_addr^2.
REQ-027 WR drives mem_rw=1, mem_addr=eff_addr and mem_wdata=word for exactly one cycle.
REQ-028 REL drives mem_rw=0 and holds mem_addr and mem_wdata.
REQ-029 mem_rw shall never be 1 in any cycle where mem_addr differs from eff_addr.
REQ-030 Latency counts rising edges from the accepting edge E0. rsp_valid rises at:
- error: E1;
- load: E(1+SETTLE);
- word store: E3;
- byte store: E(4+SETTLE).
REQ-031 req_ready = 1 only in IDLE with rst_n high. Request fields are latched at acceptance, and input changes after acceptance have no effect.
REQ-032 RESP lasts one cycle and returns to IDLE; a new request may be accepted on the edge that leaves RESP→IDLE+1, i.e. back-to-back accesses are spaced by one IDLE cycle.

Reset
REQ-033 While rst_n is low:
- state = IDLE;
- mem_rw, mem_addr, mem_wdata, rsp_valid, rsp_rdata, rsp_err, busy and req_ready = 0.
REQ-034 Reset asserted mid-access shall drop mem_rw to 0 asynchronously, abandon the access without a response, and corrupt no byte outside a write already issued in WR.

Structure
REQ-035 A shared package mem_pkg shall hold the FSM state typedef, the MEM_BYTES default, the lane-select constants and the PREP address mask 16'h0002.
REQ-036 One combinational sub-module, mem_lane_merge, shall perform lane select for loads and lane merge for byte stores; the SETTLE counter and the FSM stay in mem_access_ctrl.

Verification (bench uses the team's byte-array memory model, SETTLE=1)
REQ-037 Word store 0x1234 @0x0010 -> rsp_valid at E3, rsp_err=0; then word load @0x0010 -> rsp_rdata=0x1234 at E2.
REQ-038 Starting from REQ-037 contents, byte store 0xAB @0x0011 -> rsp at E5; word load @0x0010 -> 0x12AB; byte @0x0012 unchanged.
REQ-039 Byte store 0x5A @63, then byte load @63 -> 0x005A; byte 62 unchanged.
REQ-040 Word load @63 -> rsp_err=1, rsp_rdata=0 at E1, no mem_addr change. Byte load @64 -> rsp_err=1.
REQ-041 Word store 0xBEEF @0x0020, then two word loads @0x0020 -> both return 0xBEEF; the PREP cycle forces the refresh.
REQ-042 rst_n pulsed low during WR -> mem_rw=0 in the same cycle, no rsp_valid; next word load @0x0010 completes normally.
